router_pkt_src: RTL and testbench

- Packet transmitter for the router's input port. It collects a payload from an upstream valid/ready stream into a local buffer, then drives the router byte interface.
- Wire order is header byte, payload bytes, then parity byte, with pkt_valid high on header and payload only.
- Honours router back-pressure (busy) and enforces an inter-packet gap.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_tx_buf.sv | 24 ++
 rtl/router_pkt_src.sv | 187 ++++++++++++++++++
 tb/tb_router_pkt_src.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet source: header layout, limits and FSM state encoding.
package router_pkg;

    localparam logic [1:0]  ADDR_INVALID = 2'b11;
    localparam int unsigned LEN_W        = 6;
    localparam int unsigned MAX_LEN      = 63;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHeader,
        StPayload,
        StParity,
        StGap
    } tx_state_e;

    // Header byte: length in [7:2], destination address in [1:0].
    function automatic logic [7:0] make_header(input logic [LEN_W-1:0] len,
                                               input logic [1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer for the router packet source: 64x8, synchronous write, combinational read.
module router_tx_buf
    import router_pkg::*;
(
    input  logic             clock,
    input  logic             we,
    input  logic [LEN_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [LEN_W-1:0] raddr,
    output logic [7:0]       rdata
);

    logic [7:0] mem [MAX_LEN+1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read lets data_out pick up the next byte on the transfer edge itself.
    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_src.sv
// Router packet source: buffers a payload, then sends header, payload and parity with back-pressure.
// Optional ROUTER_PKT_SRC_ERRINJ_EN adds corrupt_parity to invert the transmitted parity byte.
module router_pkt_src
    import router_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       dest_addr,
    input  logic [LEN_W-1:0] pay_len,
    input  logic [7:0]       pay_data,
    input  logic             pay_valid,
    output logic             pay_ready,
    input  logic             busy,
    output logic             pkt_valid,
    output logic [7:0]       data_out,
    output logic             tx_busy,
    output logic             pkt_done,
    output logic             req_err,
    output logic [7:0]       sent_parity
`ifdef ROUTER_PKT_SRC_ERRINJ_EN
    ,
    input  logic             corrupt_parity
`endif
);

    tx_state_e        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       dest_q, dest_d;
    logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [7:0]       par_q, par_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       sent_par_q, sent_par_d;
    logic             req_err_q, req_err_d;
    logic             pkt_done_q, pkt_done_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             inv_par;
    logic             buf_we;
    logic [LEN_W-1:0] buf_raddr;
    logic [7:0]       buf_rdata;

    wire xfer = ~busy;

    assign buf_we    = (state_q == StLoad) && pay_valid;
    // In PAYLOAD the read port looks one byte ahead of the byte currently on the wire.
    assign buf_raddr = (state_q == StPayload) ? rd_cnt_q + 6'd1 : '0;

    router_tx_buf u_buf (
        .clock (clock),
        .we    (buf_we),
        .waddr (wr_cnt_q),
        .wdata (pay_data),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

`ifdef ROUTER_PKT_SRC_ERRINJ_EN
    logic corrupt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            corrupt_q <= 1'b0;
        end else if (state_q == StHeader && xfer) begin
            corrupt_q <= corrupt_parity;
        end
    end

    assign inv_par = corrupt_q;
`else
    assign inv_par = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        dest_d     = dest_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        par_d      = par_q;
        data_d     = data_q;
        sent_par_d = sent_par_q;
        req_err_d  = 1'b0;
        pkt_done_d = 1'b0;
        gap_cnt_d  = gap_cnt_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (dest_addr == ADDR_INVALID || pay_len == '0) begin
                        req_err_d = 1'b1;
                    end else begin
                        len_d    = pay_len;
                        dest_d   = dest_addr;
                        wr_cnt_d = '0;
                        state_d  = StLoad;
                    end
                end
            end
            StLoad: begin
                if (pay_valid) begin
                    wr_cnt_d = wr_cnt_q + 6'd1;
                    if (wr_cnt_q == len_q - 6'd1) begin
                        state_d = StHeader;
                        data_d  = make_header(len_q, dest_q);
                        par_d   = make_header(len_q, dest_q);
                    end
                end
            end
            StHeader: begin
                if (xfer) begin
                    state_d  = StPayload;
                    rd_cnt_d = '0;
                    data_d   = buf_rdata;
                end
            end
            StPayload: begin
                if (xfer) begin
                    par_d = par_q ^ data_q;
                    if (rd_cnt_q == len_q - 6'd1) begin
                        state_d = StParity;
                        data_d  = par_q ^ data_q ^ {8{inv_par}};
                    end else begin
                        rd_cnt_d = rd_cnt_q + 6'd1;
                        data_d   = buf_rdata;
                    end
                end
            end
            StParity: begin
                if (xfer) begin
                    sent_par_d = data_q;
                    pkt_done_d = 1'b1;
                    data_d     = '0;
                    gap_cnt_d  = '0;
                    state_d    = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            len_q      <= '0;
            dest_q     <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            par_q      <= '0;
            data_q     <= '0;
            sent_par_q <= '0;
            req_err_q  <= 1'b0;
            pkt_done_q <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            dest_q     <= dest_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            par_q      <= par_d;
            data_q     <= data_d;
            sent_par_q <= sent_par_d;
            req_err_q  <= req_err_d;
            pkt_done_q <= pkt_done_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign pay_ready   = (state_q == StLoad);
    assign pkt_valid   = (state_q == StHeader) || (state_q == StPayload);
    assign tx_busy     = (state_q != StIdle);
    assign data_out    = data_q;
    assign pkt_done    = pkt_done_q;
    assign req_err     = req_err_q;
    assign sent_parity = sent_par_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed self-checking bench for router_pkt_src; covers ROUTER_PKT_SRC_ERRINJ_EN when defined.
module tb_router_pkt_src;

    logic       clock     = 1'b0;
    logic       resetn    = 1'b0;
    logic       start     = 1'b0;
    logic [1:0] dest_addr = '0;
    logic [5:0] pay_len   = '0;
    logic [7:0] pay_data  = '0;
    logic       pay_valid = 1'b0;
    logic       busy      = 1'b0;
    logic       pay_ready;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_busy;
    logic       pkt_done;
    logic       req_err;
    logic [7:0] sent_parity;
`ifdef ROUTER_PKT_SRC_ERRINJ_EN
    logic       corrupt_parity = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] pay [64];

    router_pkt_src dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .dest_addr   (dest_addr),
        .pay_len     (pay_len),
        .pay_data    (pay_data),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .busy        (busy),
        .pkt_valid   (pkt_valid),
        .data_out    (data_out),
        .tx_busy     (tx_busy),
        .pkt_done    (pkt_done),
        .req_err     (req_err),
        .sent_parity (sent_parity)
`ifdef ROUTER_PKT_SRC_ERRINJ_EN
        ,
        .corrupt_parity (corrupt_parity)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_pkt(input logic [1:0] d, input logic [5:0] l, input bit gaps);
        start     = 1'b1;
        dest_addr = d;
        pay_len   = l;
        step();
        start = 1'b0;
        check("load_ready", 8'(pay_ready), 8'd1);
        for (int i = 0; i < int'(l); i++) begin
            if (gaps) begin
                pay_valid = 1'b0;
                step();
            end
            pay_data  = pay[i];
            pay_valid = 1'b1;
            step();
        end
        pay_valid = 1'b0;
        check("load_done_ready", 8'(pay_ready), 8'd0);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] d, input logic v);
        check({tag, "_data"}, data_out, d);
        check({tag, "_valid"}, 8'(pkt_valid), 8'(v));
        step();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && tx_busy; i++) begin
            step();
        end
        check("wait_idle", 8'(tx_busy), 8'd0);
    endtask

    task automatic run_std_pkt(input string tag);
        load_pkt(2'd1, 6'd4, 1'b0);
        expect_byte({tag, "_hdr"}, 8'h11, 1'b1);
        expect_byte({tag, "_p0"}, 8'h11, 1'b1);
        expect_byte({tag, "_p1"}, 8'h22, 1'b1);
        expect_byte({tag, "_p2"}, 8'h33, 1'b1);
        expect_byte({tag, "_p3"}, 8'h44, 1'b1);
        expect_byte({tag, "_par"}, 8'h55, 1'b0);
        check({tag, "_done"}, 8'(pkt_done), 8'd1);
        check({tag, "_sent"}, sent_parity, 8'h55);
    endtask

    initial begin
        pay[0] = 8'h11;
        pay[1] = 8'h22;
        pay[2] = 8'h33;
        pay[3] = 8'h44;

        // Reset state
        #2;
        check("rst_valid", 8'(pkt_valid), 8'd0);
        check("rst_data", data_out, 8'h00);
        check("rst_busy", 8'(tx_busy), 8'd0);
        check("rst_ready", 8'(pay_ready), 8'd0);
        check("rst_done", 8'(pkt_done), 8'd0);
        check("rst_err", 8'(req_err), 8'd0);
        check("rst_sent", sent_parity, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        step();

        // Basic packet plus gap timing
        run_std_pkt("t1");
        check("t1_gap_data", data_out, 8'h00);
        check("t1_gap_busy0", 8'(tx_busy), 8'd1);
        step();
        check("t1_done_pulse", 8'(pkt_done), 8'd0);
        step();
        check("t1_gap_busy2", 8'(tx_busy), 8'd1);
        step();
        check("t1_gap_end", 8'(tx_busy), 8'd0);

        // Back-pressure while 22h is on the wire
        load_pkt(2'd1, 6'd4, 1'b0);
        expect_byte("t2_hdr", 8'h11, 1'b1);
        expect_byte("t2_p0", 8'h11, 1'b1);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_byte("t2_hold", 8'h22, 1'b1);
        end
        busy = 1'b0;
        expect_byte("t2_p1", 8'h22, 1'b1);
        expect_byte("t2_p2", 8'h33, 1'b1);
        expect_byte("t2_p3", 8'h44, 1'b1);
        expect_byte("t2_par", 8'h55, 1'b0);
        check("t2_done", 8'(pkt_done), 8'd1);
        check("t2_sent", sent_parity, 8'h55);
        wait_idle();

        // Rejected requests
        start     = 1'b1;
        dest_addr = 2'd3;
        pay_len   = 6'd4;
        step();
        start = 1'b0;
        check("t3_err_addr", 8'(req_err), 8'd1);
        check("t3_ready_a", 8'(pay_ready), 8'd0);
        check("t3_busy_a", 8'(tx_busy), 8'd0);
        step();
        check("t3_err_clr", 8'(req_err), 8'd0);
        start     = 1'b1;
        dest_addr = 2'd0;
        pay_len   = 6'd0;
        step();
        start = 1'b0;
        check("t3_err_len", 8'(req_err), 8'd1);
        check("t3_valid", 8'(pkt_valid), 8'd0);
        step();
        check("t3_err_clr2", 8'(req_err), 8'd0);
        check("t3_ready_b", 8'(pay_ready), 8'd0);

        // Maximum length with pay_valid gaps; header FEh, parity FEh ^ 3Fh = C1h
        for (int i = 0; i < 63; i++) begin
            pay[i] = 8'(i);
        end
        load_pkt(2'd2, 6'd63, 1'b1);
        expect_byte("t4_hdr", 8'hFE, 1'b1);
        for (int i = 0; i < 63; i++) begin
            expect_byte("t4_pay", 8'(i), 1'b1);
        end
        expect_byte("t4_par", 8'hC1, 1'b0);
        check("t4_done", 8'(pkt_done), 8'd1);
        check("t4_sent", sent_parity, 8'hC1);
        step();
        check("t4_done_once", 8'(pkt_done), 8'd0);
        wait_idle();

        // Reset while payload byte 33h is on the wire
        pay[0] = 8'h11;
        pay[1] = 8'h22;
        pay[2] = 8'h33;
        pay[3] = 8'h44;
        load_pkt(2'd1, 6'd4, 1'b0);
        expect_byte("t5_hdr", 8'h11, 1'b1);
        expect_byte("t5_p0", 8'h11, 1'b1);
        expect_byte("t5_p1", 8'h22, 1'b1);
        check("t5_pre", data_out, 8'h33);
        #2;
        resetn = 1'b0;
        #1;
        check("t5_rst_valid", 8'(pkt_valid), 8'd0);
        check("t5_rst_data", data_out, 8'h00);
        check("t5_rst_busy", 8'(tx_busy), 8'd0);
        check("t5_rst_sent", sent_parity, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        step();
        check("t5_idle", 8'(tx_busy), 8'd0);
        run_std_pkt("t5_after");
        wait_idle();

`ifdef ROUTER_PKT_SRC_ERRINJ_EN
        // Parity corruption sampled at the header transfer edge
        load_pkt(2'd1, 6'd4, 1'b0);
        corrupt_parity = 1'b1;
        expect_byte("t6_hdr", 8'h11, 1'b1);
        corrupt_parity = 1'b0;
        expect_byte("t6_p0", 8'h11, 1'b1);
        expect_byte("t6_p1", 8'h22, 1'b1);
        expect_byte("t6_p2", 8'h33, 1'b1);
        expect_byte("t6_p3", 8'h44, 1'b1);
        expect_byte("t6_par", 8'hAA, 1'b0);
        check("t6_sent", sent_parity, 8'hAA);
        wait_idle();
        run_std_pkt("t6_clean");
        wait_idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
